// File: rtl/ram_sdp_be_if.sv
`default_nettype none
// ============================================================================
//  Module   : ram_sdp_be_if
//  Brief    : Bus bundle for ram_sdp_be: byte-enabled write port, read port
//             with valid strobe, and sweep-clear request / busy status.
//  Revision : 1.0  initial release
// ============================================================================
interface ram_sdp_be_if #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32
);
   logic                    we;
   logic [DATA_WIDTH/8-1:0] w_be;
   logic [ADDR_WIDTH-1:0]   w_addr;
   logic [DATA_WIDTH-1:0]   w_data;
   logic                    re;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [DATA_WIDTH-1:0]   r_data;
   logic                    r_valid;
   logic                    clr_req;
   logic                    busy;

   // User side: issues writes, reads and clear requests
   modport master (
      output we, w_be, w_addr, w_data, re, r_addr, clr_req,
      input  r_data, r_valid, busy
   );

   // Memory side
   modport slave (
      input  we, w_be, w_addr, w_data, re, r_addr, clr_req,
      output r_data, r_valid, busy
   );
endinterface
`default_nettype wire

// File: rtl/ram_sdp_be.sv
`default_nettype none
// ============================================================================
//  Module   : ram_sdp_be
//  Brief    : Single-clock simple dual-port block RAM with per-byte write
//             enables, 1- or 2-cycle read latency with valid strobe,
//             selectable read-during-write behaviour and a hardware
//             sweep-clear state machine.
//  Revision : 1.0  initial release
// ============================================================================
module ram_sdp_be #(
   parameter int ADDR_WIDTH     = 12,
   parameter int DATA_WIDTH     = 32,
   parameter int WORDS          = 4096,
   parameter int READ_LATENCY   = 1,
   parameter int BYPASS         = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  wire logic clk,
   input  wire logic rst,
   ram_sdp_be_if.slave bus
);

   localparam int c_NUM_BYTES = DATA_WIDTH / 8;
   // Array index width; addresses beyond WORDS are screened before indexing
   localparam int c_IDX_W     = (WORDS > 1) ? $clog2(WORDS) : 1;
   // One extra bit so that WORDS == 2**ADDR_WIDTH is representable
   localparam logic [ADDR_WIDTH:0]   c_WORDS     = WORDS[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0]   c_LAST_ADDR = c_WORDS - {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] c_ONE       = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   (* ram_style = "BLOCK" *)
   logic [DATA_WIDTH-1:0]  r_mem [0:WORDS-1];

   state_t                 r_state;
   logic                   r_busy;
   logic [ADDR_WIDTH-1:0]  r_clr_cnt;

   logic                   r_s1_valid;
   logic [DATA_WIDTH-1:0]  r_s1_data;

   logic                   w_wr_user;
   logic                   w_rd_acc;
   logic [c_NUM_BYTES-1:0] w_mem_be;
   logic [c_IDX_W-1:0]     w_mem_addr;
   logic [DATA_WIDTH-1:0]  w_mem_data;
   logic                   w_rd_in_range;
   logic [DATA_WIDTH-1:0]  w_mem_rd;
   logic [DATA_WIDTH-1:0]  w_rd_word;

   // User write qualification and write-port mux (sweep owns the port while busy)
   always_comb begin
      w_wr_user  = bus.we && !r_busy && (|bus.w_be) && ({1'b0, bus.w_addr} < c_WORDS);
      w_mem_be   = '0;
      w_mem_addr = bus.w_addr[c_IDX_W-1:0];
      w_mem_data = bus.w_data;
      if (rst) begin
         w_mem_be = '0;
      end else if (r_busy) begin
         w_mem_be   = '1;
         w_mem_addr = r_clr_cnt[c_IDX_W-1:0];
         w_mem_data = '0;
      end else if (w_wr_user) begin
         w_mem_be = bus.w_be;
      end
   end

   // Read word selection: range screen, then optional same-address forwarding
   always_comb begin
      w_rd_acc      = bus.re && !r_busy;
      w_rd_in_range = ({1'b0, bus.r_addr} < c_WORDS);
      w_mem_rd      = r_mem[bus.r_addr[c_IDX_W-1:0]];
      w_rd_word     = w_rd_in_range ? w_mem_rd : '0;
      if ((BYPASS != 0) && w_wr_user && (bus.w_addr == bus.r_addr)) begin
         for (int i = 0; i < c_NUM_BYTES; i++) begin
            if (bus.w_be[i]) begin
               w_rd_word[8*i +: 8] = bus.w_data[8*i +: 8];
            end
         end
      end
   end

   // Byte-lane array write; contents are deliberately not reset
   always_ff @(posedge clk) begin
      for (int i = 0; i < c_NUM_BYTES; i++) begin
         if (w_mem_be[i]) begin
            r_mem[w_mem_addr][8*i +: 8] <= w_mem_data[8*i +: 8];
         end
      end
   end

   // Sweep-clear controller: IDLE <-> CLEAR, one address per cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_clr_cnt <= '0;
         if (CLEAR_ON_RESET != 0) begin
            r_state <= ST_CLEAR;
            r_busy  <= 1'b1;
         end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
         end
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.clr_req) begin
                  r_state   <= ST_CLEAR;
                  r_busy    <= 1'b1;
                  r_clr_cnt <= '0;
               end
            end
            ST_CLEAR: begin
               if ({1'b0, r_clr_cnt} == c_LAST_ADDR) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_clr_cnt <= r_clr_cnt + c_ONE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // First read stage: memory sampled at the accepting edge, data held otherwise
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_data  <= '0;
      end else begin
         r_s1_valid <= w_rd_acc;
         if (w_rd_acc) begin
            r_s1_data <= w_rd_word;
         end
      end
   end

   generate
      if (READ_LATENCY == 2) begin : g_lat2
         logic                  r_s2_valid;
         logic [DATA_WIDTH-1:0] r_s2_data;

         // Output register stage; captures only completed reads so data holds
         always_ff @(posedge clk) begin
            if (rst) begin
               r_s2_valid <= 1'b0;
               r_s2_data  <= '0;
            end else begin
               r_s2_valid <= r_s1_valid;
               if (r_s1_valid) begin
                  r_s2_data <= r_s1_data;
               end
            end
         end

         assign bus.r_valid = r_s2_valid;
         assign bus.r_data  = r_s2_data;
      end else begin : g_lat1
         assign bus.r_valid = r_s1_valid;
         assign bus.r_data  = r_s1_data;
      end
   endgenerate

   assign bus.busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ram_sdp_be.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_sdp_be
//  Brief    : Directed self-checking bench. Two instances share one stimulus:
//             A = latency 1 / write-first, B = latency 2 / read-first.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ram_sdp_be;
   localparam int AW = 12;
   localparam int DW = 32;
   localparam int NW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          we;
   logic [3:0]    w_be;
   logic [AW-1:0] w_addr;
   logic [DW-1:0] w_data;
   logic          re;
   logic [AW-1:0] r_addr;
   logic          clr_req;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   ram_sdp_be_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifa ();
   ram_sdp_be_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifb ();

   assign ifa.we = we;   assign ifb.we = we;
   assign ifa.w_be = w_be;   assign ifb.w_be = w_be;
   assign ifa.w_addr = w_addr;   assign ifb.w_addr = w_addr;
   assign ifa.w_data = w_data;   assign ifb.w_data = w_data;
   assign ifa.re = re;   assign ifb.re = re;
   assign ifa.r_addr = r_addr;   assign ifb.r_addr = r_addr;
   assign ifa.clr_req = clr_req;   assign ifb.clr_req = clr_req;

   ram_sdp_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORDS(NW),
                .READ_LATENCY(1), .BYPASS(1), .CLEAR_ON_RESET(1))
   dut_a (.clk(clk), .rst(rst), .bus(ifa));

   ram_sdp_be #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORDS(NW),
                .READ_LATENCY(2), .BYPASS(0), .CLEAR_ON_RESET(1))
   dut_b (.clk(clk), .rst(rst), .bus(ifb));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
      we = 1'b1; w_addr = a; w_data = d; w_be = be;
      step();
      we = 1'b0;
   endtask

   // Read (optionally with a simultaneous write); checks timing of both instances
   task automatic rw(input string tag, input logic do_wr, input logic [3:0] be,
                     input logic [AW-1:0] wa, input logic [31:0] wd,
                     input logic [AW-1:0] ra, input logic [31:0] exp_a,
                     input logic [31:0] exp_b);
      we = do_wr; w_be = be; w_addr = wa; w_data = wd;
      re = 1'b1; r_addr = ra;
      step();
      we = 1'b0; re = 1'b0;
      check({tag, "_a_vld"},   32'(ifa.r_valid), 32'd1);
      check({tag, "_a_data"},  ifa.r_data, exp_a);
      check({tag, "_b_early"}, 32'(ifb.r_valid), 32'd0);
      step();
      check({tag, "_a_vld_drop"}, 32'(ifa.r_valid), 32'd0);
      check({tag, "_a_hold"},     ifa.r_data, exp_a);
      check({tag, "_b_vld"},      32'(ifb.r_valid), 32'd1);
      check({tag, "_b_data"},     ifb.r_data, exp_b);
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (ifa.busy && n < 40) begin
         n++;
         step();
      end
   endtask

   int n_busy;
   int n_rv;

   initial begin
      rst = 1'b1; we = 1'b0; re = 1'b0; clr_req = 1'b0;
      w_be = '0; w_addr = '0; w_data = '0; r_addr = '0;

      // Reset state and power-on sweep length
      step();
      check("rst_a_vld",  32'(ifa.r_valid), 32'd0);
      check("rst_b_vld",  32'(ifb.r_valid), 32'd0);
      check("rst_a_data", ifa.r_data, 32'd0);
      check("rst_b_data", ifb.r_data, 32'd0);
      check("rst_busy",   32'(ifb.busy), 32'd1);
      rst = 1'b0;
      count_busy(n_busy);
      check("rst_sweep_len", 32'(n_busy), 32'd16);
      check("rst_b_idle",    32'(ifb.busy), 32'd0);
      for (int a = 0; a < NW; a++) rw($sformatf("clr0_%0d", a), 1'b0, 4'h0, '0, '0, AW'(a), 32'd0, 32'd0);

      // Byte-enable merge, empty enable, out-of-range write/read
      wr(12'd5, 32'hAABBCCDD, 4'b1111);
      wr(12'd5, 32'h11223344, 4'b0101);
      rw("byte", 1'b0, 4'h0, '0, '0, 12'd5, 32'hAA22CC44, 32'hAA22CC44);
      wr(12'd5, 32'h00000000, 4'b0000);
      wr(12'd21, 32'hFFFFFFFF, 4'b1111);
      rw("be0_oor", 1'b0, 4'h0, '0, '0, 12'd5, 32'hAA22CC44, 32'hAA22CC44);
      rw("rd_oor", 1'b0, 4'h0, '0, '0, 12'd21, 32'h0, 32'h0);

      // Collisions: full word, then partial lanes
      rw("coll", 1'b1, 4'b1111, 12'd7, 32'hDEADBEEF, 12'd7, 32'hDEADBEEF, 32'h00000000);
      rw("coll_fu", 1'b0, 4'h0, '0, '0, 12'd7, 32'hDEADBEEF, 32'hDEADBEEF);
      rw("pcoll", 1'b1, 4'b0011, 12'd5, 32'h99887766, 12'd5, 32'hAA227766, 32'hAA22CC44);
      rw("pcoll_fu", 1'b0, 4'h0, '0, '0, 12'd5, 32'hAA227766, 32'hAA227766);

      // Streaming: eight back-to-back reads
      for (int a = 0; a < 8; a++) wr(AW'(a), 32'(a), 4'b1111);
      for (int s = 0; s < 10; s++) begin
         re = (s < 8); r_addr = AW'(s);
         step();
         check($sformatf("strm_a_vld_%0d", s), 32'(ifa.r_valid), (s < 8) ? 32'd1 : 32'd0);
         check($sformatf("strm_a_dat_%0d", s), ifa.r_data, (s < 8) ? 32'(s) : 32'd7);
         check($sformatf("strm_b_vld_%0d", s), 32'(ifb.r_valid), (s >= 1 && s <= 8) ? 32'd1 : 32'd0);
         if (s >= 1) check($sformatf("strm_b_dat_%0d", s), ifb.r_data, (s <= 8) ? 32'(s - 1) : 32'd7);
      end
      re = 1'b0;

      // Clear request with traffic and a second request during the sweep
      for (int a = 0; a < NW; a++) wr(AW'(a), 32'hFFFFFFFF, 4'b1111);
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      we = 1'b1; w_be = 4'b1111; w_addr = 12'd3; w_data = 32'h12345678;
      re = 1'b1; r_addr = 12'd3;
      n_busy = 0; n_rv = 0;
      while (ifa.busy && n_busy < 40) begin
         n_busy++;
         if (ifa.r_valid || ifb.r_valid) n_rv++;
         clr_req = (n_busy == 6);
         step();
      end
      we = 1'b0; re = 1'b0; clr_req = 1'b0;
      check("clr_len",    32'(n_busy), 32'd16);
      check("clr_no_vld", 32'(n_rv), 32'd0);
      check("clr_b_idle", 32'(ifb.busy), 32'd0);
      for (int a = 0; a < NW; a++) rw($sformatf("clr1_%0d", a), 1'b0, 4'h0, '0, '0, AW'(a), 32'd0, 32'd0);

      // Reset in the middle of a sweep restarts it
      for (int a = 0; a < NW; a++) wr(AW'(a), 32'hFFFFFFFF, 4'b1111);
      rw("pre_rst", 1'b0, 4'h0, '0, '0, 12'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      repeat (5) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mrst_a_vld",  32'(ifa.r_valid), 32'd0);
      check("mrst_a_data", ifa.r_data, 32'd0);
      check("mrst_b_data", ifb.r_data, 32'd0);
      check("mrst_busy",   32'(ifa.busy), 32'd1);
      count_busy(n_busy);
      check("mrst_len",    32'(n_busy), 32'd16);
      check("mrst_b_idle", 32'(ifb.busy), 32'd0);
      for (int a = 0; a < NW; a++) rw($sformatf("clr2_%0d", a), 1'b0, 4'h0, '0, '0, AW'(a), 32'd0, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ram_sdp_be.md
Name: ram_sdp_be

Overview:
- Parametrised simple dual-port block RAM with one clock. Next generation of the team's basic SDP RAM.
- Adds the following over the basic RAM:
  - per-byte write enables
  - selectable read latency (1 or 2) with a read-valid strobe
  - configurable read-during-write behaviour
  - a hardware sweep-clear state machine, replacing the simulation-only initial clear
- Used as the table/bucket store for the anonymizer datapath.

Parameters:
- ADDR_WIDTH, 12, address width in bits.
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- WORDS, 4096, depth; 1 <= WORDS <= 2**ADDR_WIDTH.
- READ_LATENCY, 1, cycles from re to r_valid/r_data; legal values 1 or 2 (2 adds an output register).
- BYPASS, 1, 1 = write-first forwarding on same-address collision; 0 = read-first (old data).
- CLEAR_ON_RESET, 1, 1 = sweep-clear the whole array after rst; 0 = no clear on reset.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- we  in  1  write enable.
- w_be  in  DATA_WIDTH/8  byte enables; bit i writes w_data[8i+7:8i].
- w_addr  in  ADDR_WIDTH  write address.
- w_data  in  DATA_WIDTH  write data.
- re  in  1  read enable.
- r_addr  in  ADDR_WIDTH  read address.
- r_data  out  DATA_WIDTH  read data.
- r_valid  out  1  high for one cycle when r_data carries the result of a read.
- clr_req  in  1  request a full sweep-clear (one-cycle pulse).
- busy  out  1  high while clearing; user traffic is ignored while high.

Behaviour:
- Reset:
  - Synchronous reset, active-high; clock is clk, reset is rst.
  - On rst: r_data = 0, r_valid = 0, read pipeline flushed.
  - FSM goes to CLEAR with counter = 0 if CLEAR_ON_RESET = 1, else to IDLE. busy = 1 in CLEAR, 0 in IDLE.
  - Array contents are not reset by rst itself; only the sweep clears them.
- FSM states IDLE and CLEAR:
  - In CLEAR: each cycle write 0 (all bytes) to address counter, then increment. After address WORDS-1 is written, go to IDLE on the next edge. A sweep takes exactly WORDS cycles of busy = 1.
  - IDLE -> CLEAR when clr_req = 1; busy rises the following cycle.
  - clr_req while in CLEAR is ignored; the sweep does not restart.
  - rst mid-sweep restarts the sweep from address 0 (if CLEAR_ON_RESET = 1), or aborts it to IDLE (if 0).
- Writes (IDLE only):
  - Write occurs when we = 1. Only lanes with w_be = 1 are updated; other lanes keep their old value.
  - w_be = 0 with we = 1 performs no write.
  - w_addr >= WORDS: write dropped.
- Reads (IDLE only):
  - A read is accepted when re = 1. The memory is sampled at that edge.
  - READ_LATENCY = 1: r_data/r_valid update on the next edge.
  - READ_LATENCY = 2: one further register stage; r_data/r_valid appear one edge later.
  - Fully pipelined: back-to-back reads give one result per cycle.
  - r_valid = 1 for exactly one cycle per accepted read.
  - r_data holds its last value when no read completes.
  - r_addr >= WORDS returns 0, with r_valid asserted.
- Collision (we and re in the same cycle, w_addr == r_addr):
  - BYPASS = 1: returned word is the merged result, new bytes in enabled lanes and old bytes elsewhere.
  - BYPASS = 0: returned word is the pre-write contents.
  - The array is updated in both cases.
- During busy:
  - we and re are ignored; no reads are accepted, so r_valid stays 0.
  - Reads already in the pipeline when busy rises still complete normally.
- Array storage attribute is ram_style = "BLOCK". There is no initial block.

Test Plan:
- Reset sweep: WORDS = 16, CLEAR_ON_RESET = 1; pulse rst for 1 cycle -> busy = 1 for exactly 16 cycles, then 0. Reading all addresses afterwards returns 0x00000000.
- Byte write:
  - Write 0xAABBCCDD to addr 5 with w_be = 4'b1111, then write 0x11223344 to addr 5 with w_be = 4'b0101.
  - Read addr 5 -> 0xAA22CC44. r_valid comes 1 cycle after re with READ_LATENCY = 1, and 2 cycles after with READ_LATENCY = 2.
- Collision:
  - addr 7 holds 0x00000000. In one cycle, write 0xDEADBEEF to addr 7 (w_be = 4'b1111) and read addr 7.
  - BYPASS = 1 -> returns 0xDEADBEEF. BYPASS = 0 -> returns 0x00000000.
  - A follow-up read returns 0xDEADBEEF in both cases.
- Streaming: re = 1 for 8 consecutive cycles on addrs 0..7 (preloaded with values 0..7) -> r_valid high for 8 consecutive cycles, data 0..7 in order.
- Clear request:
  - Fill addrs 0..15 with 0xFFFFFFFF, then pulse clr_req.
  - Assert we/re during busy -> no writes land and r_valid stays 0.
  - A second clr_req mid-sweep does not extend busy beyond 16 cycles.
  - All addresses read back 0 afterwards.
- Reset mid-sweep: assert rst at sweep cycle 6 -> busy stays high and the sweep completes 16 cycles after rst deasserts. r_valid = 0 and r_data = 0 immediately after rst.
